// File: rtl/multi_lane_hit_scorer_pkg.sv
// hit_scorer_pkg: shared lane/grade types and packed-BCD helpers for the multi-lane hit scorer.
package hit_scorer_pkg;
  typedef enum logic [1:0] {IDLE, OPEN, DONE} lane_state_t;
  typedef enum logic [1:0] {G_NONE, G_OK, G_GOOD, G_PERFECT} grade_t;
  localparam logic [15:0] BCD_MAX = 16'h9999;
  function automatic logic [7:0] bin_to_bcd8(input logic [7:0] b);
    return b > 8'd99 ? 8'h99 : {4'(b / 8'd10), 4'(b % 8'd10)};
  endfunction
  // Ripple the decimal carry through all four digits in one cycle; overflow pins at 9999.
  function automatic logic [15:0] bcd_add_sat16(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    logic [4:0] s;
    logic c;
    r = '0;
    c = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'd0, c};
      c = s > 5'd9;
      r[4*i +: 4] = c ? 4'(s - 5'd10) : s[3:0];
    end
    return c ? BCD_MAX : r;
  endfunction
endpackage

// File: rtl/multi_lane_hit_scorer_if.sv
// multi_lane_hit_scorer_if: control, lane event and score display bundle of the hit scorer.
interface multi_lane_hit_scorer_if #(parameter int NUM_LANES = 5);
  logic en;
  logic clear;
  logic [NUM_LANES-1:0] note_arrive;
  logic [NUM_LANES-1:0] pushed;
  logic [15:0] num_hits;
  logic [15:0] num_misses;
  logic [15:0] combo;
  logic [15:0] max_combo;
  logic [NUM_LANES-1:0] hit_pulse;
  logic [NUM_LANES-1:0] miss_pulse;
  logic [1:0] last_grade;
  modport master (
    output en, clear, note_arrive, pushed,
    input num_hits, num_misses, combo, max_combo, hit_pulse, miss_pulse, last_grade
  );
  modport slave (
    input en, clear, note_arrive, pushed,
    output num_hits, num_misses, combo, max_combo, hit_pulse, miss_pulse, last_grade
  );
endinterface

// File: rtl/multi_lane_hit_scorer_lane_judge.sv
// lane_judge: one lane's hit window FSM, window counter and timing grader.
module lane_judge
  import hit_scorer_pkg::*;
#(
  parameter int WIN_LEN      = 2200000,
  parameter int PERFECT_HALF = 200000,
  parameter int GOOD_HALF    = 650000,
  parameter int GHOST_MISS   = 1
) (
  input  logic   clk,
  input  logic   n_rst,
  input  logic   en,
  input  logic   arrive,
  input  logic   push,
  output logic   hit,
  output logic   miss,
  output grade_t grade
);
  localparam int CNT_W = $clog2(WIN_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0] CENTRE = CNT_W'(WIN_LEN / 2);
  localparam logic [CNT_W-1:0] PH = CNT_W'(PERFECT_HALF);
  localparam logic [CNT_W-1:0] GH = CNT_W'(GOOD_HALF);
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_OPEN = OPEN;
  localparam logic [1:0] S_DONE = DONE;
  logic [1:0] st;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] pos;
  logic [CNT_W-1:0] d;
  logic opening;
  // An arrival on an idle or finished lane opens a fresh window that a same-cycle push grades at count 0.
  always_comb begin
    opening = arrive && st != S_OPEN;
    pos = opening ? '0 : cnt;
    d = pos > CENTRE ? pos - CENTRE : CENTRE - pos;
    hit = en && push && (st == S_OPEN || opening);
    miss = en && !hit && (st == S_OPEN ? (arrive || cnt == LAST) : (st == S_IDLE && push && GHOST_MISS != 0));
    grade = !hit ? G_NONE : d <= PH ? G_PERFECT : d <= GH ? G_GOOD : G_OK;
  end
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      st <= S_IDLE;
      cnt <= '0;
    end else if (en) begin
      if (arrive) begin
        st <= (hit && opening) ? S_DONE : S_OPEN;
        cnt <= '0;
      end else if (st != S_IDLE) begin
        st <= cnt == LAST ? S_IDLE : hit ? S_DONE : st;
        cnt <= cnt == LAST ? '0 : cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/multi_lane_hit_scorer.sv
// multi_lane_hit_scorer: grades per-lane presses against note windows and keeps BCD score, misses and combos.
module multi_lane_hit_scorer
  import hit_scorer_pkg::*;
#(
  parameter int NUM_LANES    = 5,
  parameter int WIN_LEN      = 2200000,
  parameter int PERFECT_HALF = 200000,
  parameter int GOOD_HALF    = 650000,
  parameter int PTS_PERFECT  = 5,
  parameter int PTS_GOOD     = 3,
  parameter int PTS_OK       = 1,
  parameter int GHOST_MISS   = 1
) (
  input logic clk,
  input logic n_rst,
  multi_lane_hit_scorer_if.slave bus
);
  localparam logic [7:0] P_PERF = 8'(PTS_PERFECT);
  localparam logic [7:0] P_GOOD = 8'(PTS_GOOD);
  localparam logic [7:0] P_OK = 8'(PTS_OK);
  logic [NUM_LANES-1:0] hit;
  logic [NUM_LANES-1:0] miss;
  grade_t grade [NUM_LANES];
  logic [7:0] h;
  logic [7:0] m;
  logic [7:0] p;
  grade_t g;
  logic [15:0] new_combo;
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_judge #(
      .WIN_LEN(WIN_LEN), .PERFECT_HALF(PERFECT_HALF), .GOOD_HALF(GOOD_HALF), .GHOST_MISS(GHOST_MISS)
    ) u_lane (
      .clk(clk), .n_rst(n_rst), .en(bus.en), .arrive(bus.note_arrive[i]), .push(bus.pushed[i]),
      .hit(hit[i]), .miss(miss[i]), .grade(grade[i])
    );
  end
  // Walking lanes from the top down leaves the lowest-index hit's grade in g.
  always_comb begin
    h = '0;
    m = '0;
    p = '0;
    g = G_NONE;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      h = h + 8'(hit[i]);
      m = m + 8'(miss[i]);
      p = p + (!hit[i] ? 8'd0 : grade[i] == G_PERFECT ? P_PERF : grade[i] == G_GOOD ? P_GOOD : P_OK);
      g = hit[i] ? grade[i] : g;
    end
    new_combo = m != 0 ? 16'h0000 : bcd_add_sat16(bus.combo, {8'h00, bin_to_bcd8(h)});
  end
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      bus.hit_pulse <= '0;
      bus.miss_pulse <= '0;
      bus.num_hits <= '0;
      bus.num_misses <= '0;
      bus.combo <= '0;
      bus.max_combo <= '0;
      bus.last_grade <= '0;
    end else begin
      bus.hit_pulse <= hit;
      bus.miss_pulse <= miss;
      if (bus.en && bus.clear) begin
        bus.num_hits <= '0;
        bus.num_misses <= '0;
        bus.combo <= '0;
        bus.max_combo <= '0;
        bus.last_grade <= '0;
      end else if (bus.en) begin
        bus.num_hits <= bcd_add_sat16(bus.num_hits, {8'h00, bin_to_bcd8(p)});
        bus.num_misses <= bcd_add_sat16(bus.num_misses, {8'h00, bin_to_bcd8(m)});
        bus.combo <= new_combo;
        bus.max_combo <= new_combo > bus.max_combo ? new_combo : bus.max_combo;
        bus.last_grade <= h != 0 ? g : bus.last_grade;
      end
    end
  end
endmodule

// File: tb/tb_multi_lane_hit_scorer.sv
// tb_multi_lane_hit_scorer: directed scoreboard bench for the 3-lane, 20-cycle-window scorer.
module tb_multi_lane_hit_scorer;
  typedef struct {
    logic [2:0] hp;
    logic [2:0] mp;
    logic [15:0] hits;
    logic [15:0] misses;
    logic [15:0] combo;
    logic [15:0] maxc;
    logic [1:0] grade;
  } exp_t;
  exp_t sb[$];
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int compared = 0;
  int mismatched = 0;
  int m_hits = 0, m_misses = 0, m_combo = 0, m_max = 0, m_grade = 0;
  always #5 clk = ~clk;
  multi_lane_hit_scorer_if #(.NUM_LANES(3)) bus();
  multi_lane_hit_scorer #(
    .NUM_LANES(3), .WIN_LEN(20), .PERFECT_HALF(3), .GOOD_HALF(6),
    .PTS_PERFECT(5), .PTS_GOOD(3), .PTS_OK(1), .GHOST_MISS(1)
  ) dut (.clk(clk), .n_rst(n_rst), .bus(bus));
  function automatic logic [15:0] bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction
  function automatic int mn(input int a, input int b);
    return a < b ? a : b;
  endfunction
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      mismatched++;
      $error("FAIL scoreboard: no expected entry");
    end else begin
      e = sb.pop_front();
      chk("hit_pulse", 16'(bus.hit_pulse), 16'(e.hp));
      chk("miss_pulse", 16'(bus.miss_pulse), 16'(e.mp));
      chk("num_hits", bus.num_hits, e.hits);
      chk("num_misses", bus.num_misses, e.misses);
      chk("combo", bus.combo, e.combo);
      chk("max_combo", bus.max_combo, e.maxc);
      chk("last_grade", 16'(bus.last_grade), 16'(e.grade));
    end
  endtask
  task automatic push_exp(input logic [2:0] hp, input logic [2:0] mp);
    exp_t x;
    x.hp = hp;
    x.mp = mp;
    x.hits = bcd(m_hits);
    x.misses = bcd(m_misses);
    x.combo = bcd(m_combo);
    x.maxc = bcd(m_max);
    x.grade = 2'(m_grade);
    sb.push_back(x);
  endtask
  // One clock: drive inputs, predict the aggregate result of the listed lane events, check after the edge.
  task automatic cyc(input logic e, input logic clr, input logic [2:0] arr, input logic [2:0] psh,
                     input logic [2:0] hp, input logic [2:0] mp, input int pts, input int g);
    bus.en = e;
    bus.clear = clr;
    bus.note_arrive = arr;
    bus.pushed = psh;
    if (e && clr) begin
      m_hits = 0; m_misses = 0; m_combo = 0; m_max = 0; m_grade = 0;
    end else if (e) begin
      m_hits = mn(m_hits + pts, 9999);
      m_misses = mn(m_misses + $countones(mp), 9999);
      m_combo = mp != 0 ? 0 : mn(m_combo + $countones(hp), 9999);
      if (m_combo > m_max) m_max = m_combo;
      if (hp != 0) m_grade = g;
    end
    push_exp(e ? hp : 3'b000, e ? mp : 3'b000);
    @(negedge clk);
    check_out();
  endtask
  task automatic idle(input int n);
    repeat (n) cyc(1'b1, 1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0);
  endtask
  task automatic do_reset();
    n_rst = 1'b0;
    bus.en = 1'b1;
    bus.clear = 1'b0;
    bus.note_arrive = '0;
    bus.pushed = '0;
    m_hits = 0; m_misses = 0; m_combo = 0; m_max = 0; m_grade = 0;
    push_exp(3'b000, 3'b000);
    @(negedge clk);
    check_out();
    n_rst = 1'b1;
  endtask
  initial begin
    bus.en = 1'b0;
    bus.clear = 1'b0;
    bus.note_arrive = '0;
    bus.pushed = '0;
    do_reset();
    // Lane 0 PERFECT at cnt 10.
    cyc(1, 0, 3'b001, 0, 0, 0, 0, 0);
    idle(10);
    cyc(1, 0, 0, 3'b001, 3'b001, 0, 5, 3);
    // Lane 1 GOOD at cnt 4, re-arrival from DONE, then OK at cnt 1.
    cyc(1, 0, 3'b010, 0, 0, 0, 0, 0);
    idle(4);
    cyc(1, 0, 0, 3'b010, 3'b010, 0, 3, 2);
    cyc(1, 0, 3'b010, 0, 0, 0, 0, 0);
    idle(1);
    cyc(1, 0, 0, 3'b010, 3'b010, 0, 1, 1);
    // Lane 2 expires unpressed.
    cyc(1, 0, 3'b100, 0, 0, 0, 0, 0);
    idle(19);
    cyc(1, 0, 0, 0, 0, 3'b100, 0, 0);
    // Two PERFECT hits plus a ghost press in one cycle.
    cyc(1, 0, 3'b011, 0, 0, 0, 0, 0);
    idle(10);
    cyc(1, 0, 0, 3'b111, 3'b011, 3'b100, 10, 3);
    // Push lands on the expiry cycle and still grades (OK).
    cyc(1, 0, 3'b001, 0, 0, 0, 0, 0);
    idle(19);
    cyc(1, 0, 0, 3'b001, 3'b001, 0, 1, 1);
    // Arrival on an open lane misses the old note and restarts the window.
    cyc(1, 0, 3'b001, 0, 0, 0, 0, 0);
    idle(3);
    cyc(1, 0, 3'b001, 0, 0, 3'b001, 0, 0);
    idle(10);
    cyc(1, 0, 0, 3'b001, 3'b001, 0, 5, 3);
    // Clear discards the same-cycle hit but the pulse still fires.
    cyc(1, 0, 3'b010, 0, 0, 0, 0, 0);
    idle(10);
    cyc(1, 1, 0, 3'b010, 3'b010, 0, 5, 3);
    // Pause for 5 cycles mid-window; a press while paused is dropped and expiry slips by 5.
    cyc(1, 0, 3'b100, 0, 0, 0, 0, 0);
    idle(5);
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 3'b100, 0, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    idle(14);
    cyc(1, 0, 0, 0, 0, 3'b100, 0, 0);
    // Reset mid-window drops the note without a miss.
    cyc(1, 0, 3'b001, 0, 0, 0, 0, 0);
    idle(5);
    do_reset();
    idle(25);
    // Build the score up to 9998, then one more PERFECT saturates at 9999.
    for (int r = 0; r < 666; r++) begin
      cyc(1, 0, 3'b111, 0, 0, 0, 0, 0);
      idle(10);
      cyc(1, 0, 0, 3'b111, 3'b111, 0, 15, 3);
    end
    cyc(1, 0, 3'b011, 0, 0, 0, 0, 0);
    idle(4);
    cyc(1, 0, 0, 3'b010, 3'b010, 0, 3, 2);
    idle(5);
    cyc(1, 0, 0, 3'b001, 3'b001, 0, 5, 3);
    chk("preload_9998", bus.num_hits, 16'h9998);
    cyc(1, 0, 3'b001, 0, 0, 0, 0, 0);
    idle(10);
    cyc(1, 0, 0, 3'b001, 3'b001, 0, 5, 3);
    chk("saturated_9999", bus.num_hits, 16'h9999);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
